// File: rtl/mux_arbiter_ctrl_if.sv
// ---------------------------------------------------------------------------
// mux_arbiter_ctrl_if
//   Bundle between the two channel owners, the arbiter and the FET mux.
//
//   req          [1:0]  requester -> arbiter, level request per channel
//   gnt          [1:0]  arbiter -> requester, one-hot owner or 0 when idle
//   valid               arbiter -> requester, mux path settled for owner
//   s                   arbiter -> mux, channel select
//   notoe               arbiter -> mux, output enable (active low)
//   toggle_count [CNT_W-1:0]  saturating count of control-line changes
//
// Handshake: req[i] is a level held for as long as channel i is wanted.
// gnt[i] rising means the arbiter has committed the mux to channel i, but
// data may only be trusted while valid=1. Dropping req[i] at any point is a
// release; gnt[i] stays high through the disable phase and falls when the
// mux is fully off. There is no per-beat transfer, so no ready signal.
// ---------------------------------------------------------------------------
interface mux_arbiter_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [1:0]       req;
    logic [1:0]       gnt;
    logic             valid;
    logic             s;
    logic             notoe;
    logic [CNT_W-1:0] toggle_count;

    modport master (
        input  req,
        output gnt,
        output valid,
        output s,
        output notoe,
        output toggle_count
    );

    modport slave (
        output req,
        input  gnt,
        input  valid,
        input  s,
        input  notoe,
        input  toggle_count
    );
endinterface

// File: rtl/mux_arbiter_ctrl.sv
// ---------------------------------------------------------------------------
// mux_arbiter_ctrl
//   Shares a 1-of-2 FET mux between two requesters with break-before-make
//   sequencing: output disabled, select changed, output re-enabled. Each
//   phase is stretched to cover the mux enable/disable/propagation delays.
//   Round-robin on ties, bounded hold time under contention, and a
//   saturating count of control-line toggles for power accounting.
//
//   clk        in   rising-edge clock
//   reset_L    in   asynchronous active-low reset
//   bus        master modport of mux_arbiter_ctrl_if (req in; gnt, valid,
//              s, notoe, toggle_count out)
//   state_dbg  out  current FSM state (IDLE=0 SELECT=1 ENABLE=2 ACTIVE=3
//              DISABLE=4)
//
//   EN_CYCLES, DIS_CYCLES and HOLD_MAX must all be >= 1.
// ---------------------------------------------------------------------------
module mux_arbiter_ctrl #(
    parameter int EN_CYCLES  = 6,
    parameter int DIS_CYCLES = 6,
    parameter int HOLD_MAX   = 16,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                reset_L,
    mux_arbiter_ctrl_if.master  bus,
    output logic [2:0]          state_dbg
);

    localparam int MAX_A    = (EN_CYCLES > DIS_CYCLES) ? EN_CYCLES : DIS_CYCLES;
    localparam int MAX_WAIT = (MAX_A > HOLD_MAX) ? MAX_A : HOLD_MAX;
    localparam int WAIT_W   = $clog2(MAX_WAIT + 1);

    localparam logic [WAIT_W-1:0] EN_LAST   = WAIT_W'(EN_CYCLES - 1);
    localparam logic [WAIT_W-1:0] DIS_LAST  = WAIT_W'(DIS_CYCLES - 1);
    localparam logic [WAIT_W-1:0] HOLD_LAST = WAIT_W'(HOLD_MAX - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_ENABLE  = 3'd2,
        ST_ACTIVE  = 3'd3,
        ST_DISABLE = 3'd4
    } state_t;

    state_t             state, state_n;
    logic [WAIT_W-1:0]  wait_cnt, wait_n;
    // owner doubles as the round-robin pointer: it always names the most
    // recently granted requester, which is exactly what tie-break needs.
    logic               owner, owner_n;
    logic [1:0]         req_q;
    logic               s_q, s_n;
    logic               notoe_q, notoe_n;
    logic               valid_q, valid_n;
    logic [1:0]         gnt_q, gnt_n;
    logic [CNT_W-1:0]   tcnt_q, tcnt_n;
    logic               own_req, oth_req;

    assign own_req = req_q[owner];
    assign oth_req = req_q[~owner];

    // Next-state and next-output logic. Outputs are computed from the next
    // state and registered, so nothing combinational reaches the pins.
    always_comb begin
        state_n = state;
        owner_n = owner;
        wait_n  = wait_cnt;
        s_n     = s_q;
        notoe_n = 1'b1;
        valid_n = 1'b0;
        gnt_n   = 2'b00;
        tcnt_n  = tcnt_q;

        case (state)
            ST_IDLE: begin
                if (req_q != 2'b00) begin
                    state_n = ST_SELECT;
                    // Tie goes to whoever was not served last.
                    owner_n = (req_q == 2'b11) ? ~owner : req_q[1];
                end
            end
            ST_SELECT: begin
                state_n = own_req ? ST_ENABLE : ST_DISABLE;
            end
            ST_ENABLE: begin
                if (!own_req)
                    state_n = ST_DISABLE;
                else if (wait_cnt == EN_LAST)
                    state_n = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                // >= because the counter saturates: an owner that ran alone
                // for a long time yields at once when the other side asks.
                if (!own_req || (oth_req && wait_cnt >= HOLD_LAST))
                    state_n = ST_DISABLE;
            end
            ST_DISABLE: begin
                if (wait_cnt == DIS_LAST)
                    state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // One shared phase counter, cleared on every state change.
        if (state_n != state)
            wait_n = '0;
        else if (wait_cnt != '1)
            wait_n = wait_cnt + WAIT_W'(1);

        // The select moves only on the edge into SELECT, where notoe is
        // high on both sides of the edge.
        if (state == ST_IDLE && state_n == ST_SELECT)
            s_n = owner_n;

        notoe_n = !(state_n == ST_ENABLE || state_n == ST_ACTIVE);
        valid_n = (state_n == ST_ACTIVE);
        gnt_n   = (state_n == ST_IDLE) ? 2'b00 : (owner_n ? 2'b10 : 2'b01);

        // A simultaneous change of s and notoe counts once.
        if (((s_n != s_q) || (notoe_n != notoe_q)) && (tcnt_q != '1))
            tcnt_n = tcnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            owner    <= 1'b1;
            req_q    <= 2'b00;
            s_q      <= 1'b0;
            notoe_q  <= 1'b1;
            valid_q  <= 1'b0;
            gnt_q    <= 2'b00;
            tcnt_q   <= '0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_n;
            owner    <= owner_n;
            req_q    <= bus.req;
            s_q      <= s_n;
            notoe_q  <= notoe_n;
            valid_q  <= valid_n;
            gnt_q    <= gnt_n;
            tcnt_q   <= tcnt_n;
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.valid        = valid_q;
    assign bus.s            = s_q;
    assign bus.notoe        = notoe_q;
    assign bus.toggle_count = tcnt_q;
    assign state_dbg        = state;

endmodule

// File: tb/tb_mux_arbiter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mux_arbiter_ctrl
//   Bench for mux_arbiter_ctrl: directed table, contention and reset
//   sequences, randomized requests against a timeline reference model, and
//   a narrow-counter instance for toggle saturation.
// ---------------------------------------------------------------------------
module tb_mux_arbiter_ctrl;

    localparam int EN   = 6;
    localparam int DIS  = 6;
    localparam int HOLD = 16;

    logic       clk;
    logic       reset_L;
    logic [2:0] state_dbg1;
    logic [2:0] state_dbg2;

    int checks = 0;
    int errors = 0;

    mux_arbiter_ctrl_if #(.CNT_W(16)) bus1 ();
    mux_arbiter_ctrl_if #(.CNT_W(2))  bus2 ();

    mux_arbiter_ctrl #(
        .EN_CYCLES(EN), .DIS_CYCLES(DIS), .HOLD_MAX(HOLD), .CNT_W(16)
    ) dut (
        .clk(clk), .reset_L(reset_L), .bus(bus1), .state_dbg(state_dbg1)
    );

    mux_arbiter_ctrl #(
        .EN_CYCLES(EN), .DIS_CYCLES(DIS), .HOLD_MAX(HOLD), .CNT_W(2)
    ) dut_sat (
        .clk(clk), .reset_L(reset_L), .bus(bus2), .state_dbg(state_dbg2)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 50)
                $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Describes a grant session by the edge numbers at which its phases
    // begin: g = SELECT, a = first ACTIVE edge, r = release into DISABLE.
    // Decisions at edge i use the request level present at edge i-1.
    int         cyc;
    bit         sess;
    int         own, last_m, g, a, r;
    logic [1:0] pr;
    logic [1:0] gnt_e;
    logic       s_e, notoe_e, valid_e;
    logic       ps_e, pnotoe_e;
    logic [15:0] tc_e;

    task automatic m_reset();
        sess = 0; own = 0; last_m = 1; g = 0; a = -1; r = -1; pr = 2'b00;
        gnt_e = 2'b00; s_e = 1'b0; notoe_e = 1'b1; valid_e = 1'b0;
        ps_e = 1'b0; pnotoe_e = 1'b1; tc_e = 16'd0;
    endtask

    task automatic m_step(input logic [1:0] req_now);
        int i;
        cyc = cyc + 1;
        i = cyc;
        if (!sess) begin
            if (pr != 2'b00) begin
                if (pr == 2'b11) own = 1 - last_m;
                else             own = pr[1] ? 1 : 0;
                last_m = own; g = i; a = -1; r = -1; sess = 1;
                s_e = (own == 1);
            end
        end else if (r < 0) begin
            if (i - 1 <= g + EN) begin
                if (!pr[own])              r = i;
                else if (i - 1 == g + EN)  a = i;
            end else if (!pr[own] || (pr[1-own] && (i - a) >= HOLD)) begin
                r = i;
            end
        end else if (i == r + DIS) begin
            sess = 0;
        end
        gnt_e   = sess ? ((own == 1) ? 2'b10 : 2'b01) : 2'b00;
        notoe_e = !(sess && r < 0 && i > g);
        valid_e = sess && r < 0 && a >= 0 && i >= a;
        if (((s_e != ps_e) || (notoe_e != pnotoe_e)) && tc_e != 16'hFFFF)
            tc_e = tc_e + 16'd1;
        ps_e = s_e;
        pnotoe_e = notoe_e;
        pr = req_now;
    endtask

    initial begin
        cyc = 0;
        m_reset();
        forever begin
            @(posedge clk or negedge reset_L);
            if (!reset_L) m_reset();
            else          m_step(bus1.req);
        end
    end

    // Model comparison every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_L) begin
                check("model_gnt",   {30'd0, bus1.gnt}, {30'd0, gnt_e});
                check("model_s",     {31'd0, bus1.s}, {31'd0, s_e});
                check("model_notoe", {31'd0, bus1.notoe}, {31'd0, notoe_e});
                check("model_valid", {31'd0, bus1.valid}, {31'd0, valid_e});
                check("model_tcnt",  {16'd0, bus1.toggle_count}, {16'd0, tc_e});
            end
        end
    end

    // The select must never move while the output is enabled.
    logic prev_s, prev_notoe, prev_rst;
    initial begin
        prev_s = 1'b0; prev_notoe = 1'b1; prev_rst = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_L && prev_rst && (prev_notoe == 1'b0 || bus1.notoe == 1'b0))
                check("s_stable_while_enabled", {31'd0, bus1.s}, {31'd0, prev_s});
            prev_s = bus1.s; prev_notoe = bus1.notoe; prev_rst = reset_L;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset(input logic [1:0] r1);
        @(negedge clk);
        reset_L  = 1'b0;
        bus1.req = r1;
        bus2.req = 2'b00;
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    task automatic check_outs(input string tag, input logic [1:0] gnt,
                              input logic s, input logic notoe,
                              input logic valid, input logic [15:0] tc);
        check({tag, "_gnt"},   {30'd0, bus1.gnt}, {30'd0, gnt});
        check({tag, "_s"},     {31'd0, bus1.s}, {31'd0, s});
        check({tag, "_notoe"}, {31'd0, bus1.notoe}, {31'd0, notoe});
        check({tag, "_valid"}, {31'd0, bus1.valid}, {31'd0, valid});
        check({tag, "_tcnt"},  {16'd0, bus1.toggle_count}, {16'd0, tc});
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [1:0]  req;
        int          n;
        logic [1:0]  gnt;
        logic        s;
        logic        notoe;
        logic        valid;
        logic [15:0] tc;
    } vec_t;

    vec_t vecs[17];

    int run_q[$];
    int gap_q[$];
    int own_q[$];

    initial begin
        // single request on channel 1, release, then channel 0 with abort
        vecs[0]  = '{2'b10,  1, 2'b00, 1'b0, 1'b1, 1'b0, 16'd0};
        vecs[1]  = '{2'b10,  1, 2'b10, 1'b1, 1'b1, 1'b0, 16'd1};
        vecs[2]  = '{2'b10,  1, 2'b10, 1'b1, 1'b0, 1'b0, 16'd2};
        vecs[3]  = '{2'b10,  5, 2'b10, 1'b1, 1'b0, 1'b0, 16'd2};
        vecs[4]  = '{2'b10,  1, 2'b10, 1'b1, 1'b0, 1'b1, 16'd2};
        vecs[5]  = '{2'b10, 20, 2'b10, 1'b1, 1'b0, 1'b1, 16'd2};
        vecs[6]  = '{2'b00,  1, 2'b10, 1'b1, 1'b0, 1'b1, 16'd2};
        vecs[7]  = '{2'b00,  1, 2'b10, 1'b1, 1'b1, 1'b0, 16'd3};
        vecs[8]  = '{2'b00,  5, 2'b10, 1'b1, 1'b1, 1'b0, 16'd3};
        vecs[9]  = '{2'b00,  1, 2'b00, 1'b1, 1'b1, 1'b0, 16'd3};
        vecs[10] = '{2'b01,  2, 2'b01, 1'b0, 1'b1, 1'b0, 16'd4};
        vecs[11] = '{2'b01,  1, 2'b01, 1'b0, 1'b0, 1'b0, 16'd5};
        vecs[12] = '{2'b01,  2, 2'b01, 1'b0, 1'b0, 1'b0, 16'd5};
        vecs[13] = '{2'b00,  1, 2'b01, 1'b0, 1'b0, 1'b0, 16'd5};
        vecs[14] = '{2'b00,  1, 2'b01, 1'b0, 1'b1, 1'b0, 16'd6};
        vecs[15] = '{2'b00,  5, 2'b01, 1'b0, 1'b1, 1'b0, 16'd6};
        vecs[16] = '{2'b00,  1, 2'b00, 1'b0, 1'b1, 1'b0, 16'd6};

        reset_L  = 1'b0;
        bus1.req = 2'b11;
        bus2.req = 2'b00;

        // Reset held with both requesting.
        repeat (3) @(negedge clk);
        check_outs("reset", 2'b00, 1'b0, 1'b1, 1'b0, 16'd0);
        reset_L = 1'b1;
        @(negedge clk);
        check("reset_first_edge_gnt", {30'd0, bus1.gnt}, 32'd0);
        @(negedge clk);
        check("reset_tie_gnt", {30'd0, bus1.gnt}, 32'd1);

        // Directed table from a fresh reset.
        do_reset(2'b00);
        for (int k = 0; k < 17; k++) begin
            bus1.req = vecs[k].req;
            repeat (vecs[k].n) @(negedge clk);
            check_outs($sformatf("vec%0d", k), vecs[k].gnt, vecs[k].s,
                       vecs[k].notoe, vecs[k].valid, vecs[k].tc);
        end

        // Contention: measure valid-high runs and the gaps between them.
        do_reset(2'b11);
        begin
            int  len;
            int  gap;
            bit  pv;
            bit  seen;
            len = 0; gap = 0; pv = 0; seen = 0;
            for (int c = 0; c < 130; c++) begin
                @(negedge clk);
                if (bus1.valid) begin
                    if (!pv) begin
                        if (seen) gap_q.push_back(gap);
                        own_q.push_back(bus1.gnt[1] ? 1 : 0);
                        len = 0;
                    end
                    len++;
                end else begin
                    if (pv) begin
                        run_q.push_back(len);
                        seen = 1;
                        gap = 0;
                    end
                    gap++;
                end
                pv = bus1.valid;
            end
        end
        check("contention_runs_seen", (run_q.size() >= 3) ? 32'd1 : 32'd0, 32'd1);
        if (run_q.size() >= 3 && gap_q.size() >= 2 && own_q.size() >= 3) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("contention_run%0d_len", k), run_q[k], HOLD);
                check($sformatf("contention_run%0d_owner", k), own_q[k], k % 2);
            end
            for (int k = 0; k < 2; k++)
                check($sformatf("contention_gap%0d", k), gap_q[k], EN + DIS + 2);
        end

        // Mid-operation reset while channel 1 is active.
        do_reset(2'b10);
        repeat (12) @(negedge clk);
        check_outs("pre_midreset", 2'b10, 1'b1, 1'b0, 1'b1, 16'd2);
        @(posedge clk);
        #3;
        reset_L = 1'b0;
        #1;
        check_outs("midreset", 2'b00, 1'b0, 1'b1, 1'b0, 16'd0);
        @(negedge clk);
        bus1.req = 2'b00;
        reset_L  = 1'b1;

        // Randomized requests, with occasional asynchronous resets.
        for (int seg = 0; seg < 80; seg++) begin
            bus1.req = 2'($urandom_range(0, 3));
            repeat ($urandom_range(1, 30)) @(negedge clk);
            if ($urandom_range(0, 19) == 0) begin
                @(posedge clk);
                #3;
                reset_L = 1'b0;
                @(negedge clk);
                reset_L = 1'b1;
            end
        end
        bus1.req = 2'b00;

        // Saturation on the 2-bit counter instance.
        do_reset(2'b00);
        for (int k = 0; k < 5; k++) begin
            bus2.req = 2'b01;
            repeat (12) @(negedge clk);
            bus2.req = 2'b00;
            repeat (10) @(negedge clk);
            if (k == 0)
                check("sat_first_cycle_tcnt", {30'd0, bus2.toggle_count}, 32'd2);
        end
        check("sat_final_tcnt", {30'd0, bus2.toggle_count}, 32'd3);
        check("sat_final_gnt", {30'd0, bus2.gnt}, 32'd0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_arbiter_ctrl.md
# mux_arbiter_ctrl

Clocked controller that shares the 1-of-2 FET multiplexer between two requesters. It drives the mux select `s` and active-low output enable `notoe` with break-before-make sequencing: the output is disabled, the select is changed, and the output is re-enabled. Each phase is held for a parameterised number of cycles that covers the mux disable, enable and propagation delays. It sits between the two channel owners and the mux model, and also keeps a saturating count of control-line toggles for power accounting.

## Interface
- `EN_CYCLES`, 6: cycles `notoe` is held low before the path is declared valid. Covers tenmax/tpdmax of 5.3 ns at a 1 ns clock; must be ≥1.
- `DIS_CYCLES`, 6: cycles `notoe` is held high after release before any new select. Covers tdismax of 5.5 ns; must be ≥1.
- `HOLD_MAX`, 16: maximum ACTIVE cycles for one owner while the other requester is waiting; must be ≥1.
- `CNT_W`, 16: width of the toggle counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_L`  in  1  asynchronous, active-low reset.
- `req`  in  2  `req[i]` high = requester i wants mux channel i; level, held while needed.
- `gnt`  out  2  one-hot ownership, or 0 when idle.
- `valid`  out  1  output path stable for the owner; high only in ACTIVE.
- `s`  out  1  mux select; `s=i` routes channel i.
- `notoe`  out  1  mux output enable, active low.
- `toggle_count`  out  CNT_W  number of edges at which `s` or `notoe` changed; saturates at all-ones.

## Operation
- Reset, asynchronous on `reset_L`=0 and effective immediately, even mid-sequence:
  - state IDLE; `notoe`=1, `s`=0, `gnt`=0, `valid`=0, `toggle_count`=0.
  - Round-robin pointer `last`=1, so `req[0]` wins the first tie.
- States:
  - **IDLE**: `notoe`=1, `gnt`=0. If any `req` is set, pick the owner (single requester, or on a tie the one ≠ `last`), then go to SELECT.
  - **SELECT** (1 cycle): `s` is loaded with the owner index while `notoe` stays 1. `gnt[owner]`=1, `last` is updated to owner. Then go to ENABLE.
  - **ENABLE** (EN_CYCLES cycles): `notoe`=0, `valid`=0. Then go to ACTIVE.
  - **ACTIVE**: `valid`=1 and the hold counter increments each cycle. Go to DISABLE when `req[owner]`=0, or when `req[other]`=1 and the hold counter reaches HOLD_MAX.
  - **DISABLE** (DIS_CYCLES cycles): `notoe`=1, `valid`=0, `gnt` still held. Then go to IDLE with `gnt`=0.
- Abort rule: if `req[owner]` drops in SELECT or ENABLE, the next state is DISABLE. The full DIS_CYCLES are still served.
- `s` only ever changes on the edge into SELECT, so `s` never changes while `notoe`=0. This invariant is required.
- `s` is held through IDLE; it is not returned to 0.
- If the same owner is re-granted, `s` does not change and is not counted as a toggle.
- `toggle_count` increments by 1 on each edge where `s` or `notoe` changes. It increments only once if both change on the same edge, and it stops at 2^CNT_W−1.
- Phase wait counters are sized to hold max(EN_CYCLES, DIS_CYCLES, HOLD_MAX). The hold counter is cleared on entry to ACTIVE.

## Timing
- All outputs are registered; there is no combinational path from `req` to any output.
- Request seen in IDLE at edge k:
  - SELECT at k+1 (`s`, `gnt` valid).
  - `notoe`=0 at k+2.
  - `valid`=1 at k+2+EN_CYCLES; with defaults, k+8.
- Release with `req[owner]`=0 seen at edge m in ACTIVE:
  - `valid`=0 and `notoe`=1 at m+1.
  - IDLE with `gnt`=0 at m+1+DIS_CYCLES.
  - The earliest next SELECT is one edge later.
- Switch-over latency from one owner's release to the other's `valid` is DIS_CYCLES+EN_CYCLES+2 cycles; with defaults, 14.
- Simultaneous owner drop and hold expiry are handled as a normal release; behaviour is identical.

## Test plan
- Reset: hold `reset_L`=0 with `req`=2'b11. Required: `notoe`=1, `s`=0, `gnt`=0, `valid`=0, `toggle_count`=0. Release reset and `gnt`=2'b01 appears 1 cycle after the first sampling edge.
- Single request: `req`=2'b10 held. Required: `s`=1 at k+1, `notoe`=0 at k+2, `valid`=1 at k+8. Drop `req` and `notoe`=1 next edge, `gnt`=0 six cycles later; `toggle_count`=3.
- Contention: `req`=2'b11 continuously. Required: owner 0 is ACTIVE exactly 16 cycles, then owner 1, alternating. `valid` gap between owners is 14 cycles, and `s` never changes while `notoe`=0 (assert every cycle).
- Abort: drop `req[0]` 3 cycles into ENABLE. Required: `valid` never rises, `notoe`=1 next edge, IDLE after 6 DISABLE cycles.
- Mid-operation reset: assert `reset_L`=0 in ACTIVE between clock edges. Required: `notoe`=1, `gnt`=0, `valid`=0 immediately without a clock, and `toggle_count`=0.
- Saturation: CNT_W=2, run 5 grant/release cycles. Required: `toggle_count` sticks at 3.
